// File: rtl/io_unit.sv
// Basic-computer style I/O unit: input/output registers with FGI/FGO flags and
// optional interrupt logic (IEN/R), enabled by defining IO_UNIT_INTR_EN.
module io_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dev_in_data,
  input  logic        dev_in_valid,
  output logic        dev_in_ready,
  output logic [15:0] inpr,
  output logic        fgi,
  input  logic        inp_ack,
  input  logic [15:0] ac,
  input  logic        out_load,
  output logic [15:0] outr,
  output logic        dev_out_valid,
  input  logic        dev_out_ready,
  output logic        fgo,
  input  logic        ien_set,
  input  logic        ien_clr,
  input  logic        irq_ack,
  output logic        ien,
  output logic        irq
);

  assign dev_in_ready  = ~fgi;
  assign dev_out_valid = ~fgo;

  // While fgi is set the device is ignored, so an ack and a new word never
  // land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      inpr <= '0;
      fgi  <= 1'b0;
    end else if (fgi) begin
      if (inp_ack) fgi <= 1'b0;
    end else if (dev_in_valid) begin
      inpr <= dev_in_data;
      fgi  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outr <= '0;
      fgo  <= 1'b1;
    end else if (fgo) begin
      if (out_load) begin
        outr <= ac;
        fgo  <= 1'b0;
      end
    end else if (dev_out_ready) begin
      fgo <= 1'b1;
    end
  end

`ifdef IO_UNIT_INTR_EN
  always_ff @(posedge clk) begin
    if (rst || irq_ack) begin
      ien <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ien_clr)      ien <= 1'b0;
      else if (ien_set) ien <= 1'b1;
      if (ien && (fgi || fgo)) irq <= 1'b1;
    end
  end
`else
  logic unused_intr;
  assign unused_intr = ien_set ^ ien_clr ^ irq_ack;
  assign ien = 1'b0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_unit.sv
// Self-checking bench for io_unit: directed scenarios followed by randomized
// traffic against a transaction-level reference model.
module tb_io_unit;

`ifdef IO_UNIT_INTR_EN
  localparam logic INTR = 1'b1;
`else
  localparam logic INTR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dev_in_data;
  logic        dev_in_valid;
  logic        dev_in_ready;
  logic [15:0] inpr;
  logic        fgi;
  logic        inp_ack;
  logic [15:0] ac;
  logic        out_load;
  logic [15:0] outr;
  logic        dev_out_valid;
  logic        dev_out_ready;
  logic        fgo;
  logic        ien_set;
  logic        ien_clr;
  logic        irq_ack;
  logic        ien;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference state
  logic [15:0] m_inpr, m_outr;
  logic        m_fgi, m_fgo, m_ien, m_irq;

  io_unit dut (
    .clk(clk), .rst(rst),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .inpr(inpr), .fgi(fgi), .inp_ack(inp_ack),
    .ac(ac), .out_load(out_load), .outr(outr),
    .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready), .fgo(fgo),
    .ien_set(ien_set), .ien_clr(ien_clr), .irq_ack(irq_ack),
    .ien(ien), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance the model by one clock using the transfers the rules permit.
  task automatic model_edge();
    logic word_in, word_read, word_loaded, word_taken, want_irq;
    if (rst) begin
      m_inpr = '0; m_fgi = 1'b0; m_outr = '0; m_fgo = 1'b1; m_ien = 1'b0; m_irq = 1'b0;
      return;
    end
    word_in     = dev_in_valid && !m_fgi;
    word_read   = inp_ack && m_fgi;
    word_loaded = out_load && m_fgo;
    word_taken  = dev_out_ready && !m_fgo;
    want_irq    = m_ien && (m_fgi || m_fgo);
    if (word_in)     begin m_inpr = dev_in_data; m_fgi = 1'b1; end
    if (word_read)   m_fgi = 1'b0;
    if (word_loaded) begin m_outr = ac; m_fgo = 1'b0; end
    if (word_taken)  m_fgo = 1'b1;
    if (INTR) begin
      if (irq_ack) begin
        m_ien = 1'b0; m_irq = 1'b0;
      end else begin
        m_irq = m_irq || want_irq;
        m_ien = ien_clr ? 1'b0 : (ien_set ? 1'b1 : m_ien);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("inpr", inpr, m_inpr);
    check("fgi", 16'(fgi), 16'(m_fgi));
    check("outr", outr, m_outr);
    check("fgo", 16'(fgo), 16'(m_fgo));
    check("ien", 16'(ien), 16'(m_ien));
    check("irq", 16'(irq), 16'(m_irq));
    check("dev_in_ready", 16'(dev_in_ready), 16'(!m_fgi));
    check("dev_out_valid", 16'(dev_out_valid), 16'(!m_fgo));
  endtask

  task automatic idle();
    rst = 1'b0; dev_in_valid = 1'b0; inp_ack = 1'b0; out_load = 1'b0;
    dev_out_ready = 1'b0; ien_set = 1'b0; ien_clr = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_inpr"}, inpr, 16'h0000);
    check({tag, "_fgi"}, 16'(fgi), 16'h0);
    check({tag, "_outr"}, outr, 16'h0000);
    check({tag, "_fgo"}, 16'(fgo), 16'h1);
    check({tag, "_ien"}, 16'(ien), 16'h0);
    check({tag, "_irq"}, 16'(irq), 16'h0);
    check({tag, "_in_ready"}, 16'(dev_in_ready), 16'h1);
    check({tag, "_out_valid"}, 16'(dev_out_valid), 16'h0);
  endtask

  initial begin
    idle();
    dev_in_data = '0; ac = '0;
    m_inpr = '0; m_outr = '0; m_fgi = 1'b0; m_fgo = 1'b1; m_ien = 1'b0; m_irq = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // input path
    dev_in_data = 16'hA5C3; dev_in_valid = 1'b1;
    step();
    dev_in_valid = 1'b0;
    check("in_inpr", inpr, 16'hA5C3);
    check("in_fgi", 16'(fgi), 16'h1);
    check("in_ready", 16'(dev_in_ready), 16'h0);
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    check("ack_fgi", 16'(fgi), 16'h0);
    check("ack_inpr", inpr, 16'hA5C3);

    // input backpressure, ack and valid together
    dev_in_data = 16'h5A5A; dev_in_valid = 1'b1;
    step();
    dev_in_data = 16'h1111;
    step();
    check("bp_inpr", inpr, 16'h5A5A);
    check("bp_fgi", 16'(fgi), 16'h1);
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    check("bp_ack_fgi", 16'(fgi), 16'h0);
    check("bp_ack_inpr", inpr, 16'h5A5A);
    step();
    dev_in_valid = 1'b0;
    check("bp_new_inpr", inpr, 16'h1111);
    check("bp_new_fgi", 16'(fgi), 16'h1);
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;

    // output path
    ac = 16'h00FF; out_load = 1'b1;
    step();
    check("out_outr", outr, 16'h00FF);
    check("out_fgo", 16'(fgo), 16'h0);
    check("out_valid", 16'(dev_out_valid), 16'h1);
    ac = 16'h1234;
    step();
    out_load = 1'b0;
    check("drop_outr", outr, 16'h00FF);
    dev_out_ready = 1'b1;
    step();
    dev_out_ready = 1'b0;
    check("take_fgo", 16'(fgo), 16'h1);
    check("take_outr", outr, 16'h00FF);

    // interrupt
    ien_set = 1'b1;
    step();
    ien_set = 1'b0;
    check("int_ien", 16'(ien), 16'(INTR));
    check("int_irq_early", 16'(irq), 16'h0);
    step();
    check("int_irq", 16'(irq), 16'(INTR));
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("ack_irq", 16'(irq), 16'h0);
    check("ack_ien", 16'(ien), 16'h0);
    ien_set = 1'b1;
    step();
    ien_clr = 1'b1;
    step();
    ien_set = 1'b0; ien_clr = 1'b0;
    check("setclr_ien", 16'(ien), 16'h0);

    // reset mid-operation
    dev_in_data = 16'hCAFE; dev_in_valid = 1'b1; ac = 16'hBEEF; out_load = 1'b1; ien_set = 1'b1;
    step();
    idle();
    step();
    check("mid_fgi", 16'(fgi), 16'h1);
    check("mid_fgo", 16'(fgo), 16'h0);
    check("mid_irq", 16'(irq), 16'(INTR));
    rst = 1'b1; dev_in_valid = 1'b1; out_load = 1'b1; ien_set = 1'b1; dev_out_ready = 1'b1;
    step();
    idle();
    check_reset_state("mid_reset");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      dev_in_data   = 16'($urandom);
      dev_in_valid  = ($urandom_range(0, 2) != 0);
      inp_ack       = ($urandom_range(0, 2) == 0);
      ac            = 16'($urandom);
      out_load      = ($urandom_range(0, 2) != 0);
      dev_out_ready = ($urandom_range(0, 2) == 0);
      ien_set       = ($urandom_range(0, 3) == 0);
      ien_clr       = ($urandom_range(0, 7) == 0);
      irq_ack       = ($urandom_range(0, 5) == 0);
      step();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
